or1200_dc_wb_burst: RTL and testbench



---
 rtl/or1200_dc_wb_pkg.sv | 25 ++
 rtl/or1200_dc_wb_beat_addr.sv | 60 ++++++
 rtl/or1200_dc_wb_burst.sv | 219 +++++++++++++++++++++
 tb/tb_or1200_dc_wb_burst.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_dc_wb_pkg.sv
// Shared types and Wishbone encodings for the data-cache bus interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional feature macro: OR1200_DC_WB_RETRY_EN adds the RETRY state.
package or1200_dc_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SINGLE,
      ST_BURST,
      ST_DONE
`ifdef OR1200_DC_WB_RETRY_EN
      , ST_RETRY
`endif
   } state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;

endpackage

// File: rtl/or1200_dc_wb_beat_addr.sv
// Beat counter plus wrapping word-address generator for cache-line bursts.
// Latency: address/last are registered state, visible the cycle after clr/adv.
// Backpressure: none; advances only when the caller pulses adv_i.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   clr_i              load start_addr_i as the base, zero the beat counter
//   start_addr_i       start byte address of the transfer
//   adv_i              step to the next beat
//   addr_o             current beat address (word offset wraps within the line)
//   last_o             current beat is the final beat of a burst
module or1200_dc_wb_beat_addr #(
   parameter int AW        = 32,
   parameter int BURST_LEN = 4     // power of two, >= 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic [AW-1:0] start_addr_i,
   input  logic          adv_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o
);

   localparam int CW = $clog2(BURST_LEN);

   logic [AW-1:0] base_q, base_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      base_d = base_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         base_d = start_addr_i;
         cnt_d  = '0;
      end else if (adv_i) begin
         cnt_d  = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         base_q <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         cnt_q  <= cnt_d;
      end
   end

   // Only the word-offset bits inside the line move; the line address and
   // the byte offset stay as latched, which gives the critical-word-first wrap.
   always_comb begin
      addr_o          = base_q;
      addr_o[CW+1:2]  = base_q[CW+1:2] + cnt_q;
   end

   assign last_o = (cnt_q == CW'(BURST_LEN - 1));

endmodule

// File: rtl/or1200_dc_wb_burst.sv
// Wishbone B3 master turning data-cache FSM level requests into single or wrapping burst cycles.
// Latency: cyc/stb rise 1 cycle after a request; valid/error are combinational from the slave response.
// Backpressure: holds each beat until the slave acks; an FSM that drops its request aborts the cycle.
//
// Optional feature macro: OR1200_DC_WB_RETRY_EN (rty re-issues the beat after a gap,
// bounded by RETRY_MAX; without it rty terminates the cycle like err).
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   biu_read, biu_write, burst     FSM request levels; burst sampled at start
//   biu_addr, biu_sel              start address and byte selects, sampled at start
//   biu_dat_i / biu_dat_o          write data in / read data out (pass-through)
//   biudata_valid, biudata_error   per-beat completion and error pulses to the FSM
//   wb_*_o / wb_*_i                Wishbone master side
module or1200_dc_wb_burst
   import or1200_dc_wb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int BURST_LEN = 4,
   parameter int RETRY_MAX = 7,
   parameter int RETRY_GAP = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            biu_read,
   input  logic            biu_write,
   input  logic            burst,
   input  logic [AW-1:0]   biu_addr,
   input  logic [DW/8-1:0] biu_sel,
   input  logic [DW-1:0]   biu_dat_i,
   output logic            biudata_valid,
   output logic            biudata_error,
   output logic [DW-1:0]   biu_dat_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i,
   input  logic [DW-1:0]   wb_dat_i
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [DW/8-1:0]   sel_q, sel_d;

   logic              ba_clr, ba_adv, ba_last;
   logic [AW-1:0]     ba_addr;

   logic              req, bus_act, live;
   logic              term_err, err_ev, ack_ev, exhaust_ev;

   or1200_dc_wb_beat_addr #(
      .AW        (AW),
      .BURST_LEN (BURST_LEN)
   ) u_beat_addr (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (ba_clr),
      .start_addr_i (biu_addr),
      .adv_i        (ba_adv),
      .addr_o       (ba_addr),
      .last_o       (ba_last)
   );

   assign req     = biu_read | biu_write;
   assign bus_act = (state_q == ST_SINGLE) || (state_q == ST_BURST);
   // A response only counts while the strobe is out, the FSM still wants the
   // data and reset is not asserted.
   assign live    = bus_act & req & rst;

`ifdef OR1200_DC_WB_RETRY_EN
   localparam int RCW = $clog2(RETRY_MAX + 1);
   localparam int GCW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   localparam logic [RCW-1:0] RTY_LIMIT = RCW'(RETRY_MAX);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'(RETRY_GAP - 1);

   logic [RCW-1:0] rty_cnt_q, rty_cnt_d;
   logic [GCW-1:0] gap_q, gap_d;
   logic           burst_q, burst_d;
   logic           rty_ev;

   assign term_err   = wb_err_i;
   assign rty_ev     = live & wb_rty_i & ~wb_err_i;
   assign exhaust_ev = rty_ev & (rty_cnt_q == RTY_LIMIT);
   assign ack_ev     = live & wb_ack_i & ~wb_err_i & ~wb_rty_i;
`else
   logic unused_retry_cfg;
   assign unused_retry_cfg = (RETRY_MAX + RETRY_GAP) != 0;

   assign term_err   = wb_err_i | wb_rty_i;
   assign exhaust_ev = 1'b0;
   assign ack_ev     = live & wb_ack_i & ~term_err;
`endif

   assign err_ev        = live & term_err;
   assign biudata_valid = ack_ev;
   assign biudata_error = err_ev | exhaust_ev;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      sel_d   = sel_q;
      ba_clr  = 1'b0;
      ba_adv  = 1'b0;
`ifdef OR1200_DC_WB_RETRY_EN
      rty_cnt_d = rty_cnt_q;
      gap_d     = gap_q;
      burst_d   = burst_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               ba_clr  = 1'b1;
               we_d    = biu_write;      // write wins when both are high
               sel_d   = biu_sel;
               state_d = burst ? ST_BURST : ST_SINGLE;
`ifdef OR1200_DC_WB_RETRY_EN
               rty_cnt_d = '0;
               burst_d   = burst;
`endif
            end
         end
         ST_SINGLE, ST_BURST: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (err_ev) begin
               state_d = ST_DONE;
`ifdef OR1200_DC_WB_RETRY_EN
            end else if (rty_ev) begin
               if (exhaust_ev) begin
                  state_d = ST_DONE;
               end else begin
                  rty_cnt_d = rty_cnt_q + RCW'(1);
                  gap_d     = '0;
                  state_d   = ST_RETRY;
               end
`endif
            end else if (ack_ev) begin
`ifdef OR1200_DC_WB_RETRY_EN
               rty_cnt_d = '0;
`endif
               if ((state_q == ST_SINGLE) || ba_last) begin
                  state_d = ST_DONE;
               end else begin
                  ba_adv = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (!req) begin
               state_d = ST_IDLE;
            end
         end
`ifdef OR1200_DC_WB_RETRY_EN
         ST_RETRY: begin
            // Beat counter is untouched here, so the re-issue hits the same
            // address and its cti is recomputed from the same beat position.
            if (!req) begin
               state_d = ST_IDLE;
            end else if (gap_q == GAP_LAST) begin
               state_d = burst_q ? ST_BURST : ST_SINGLE;
            end else begin
               gap_d = gap_q + GCW'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         sel_q   <= '0;
`ifdef OR1200_DC_WB_RETRY_EN
         rty_cnt_q <= '0;
         gap_q     <= '0;
         burst_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
`ifdef OR1200_DC_WB_RETRY_EN
         rty_cnt_q <= rty_cnt_d;
         gap_q     <= gap_d;
         burst_q   <= burst_d;
`endif
      end
   end

   // Bus qualifiers are forced to zero outside an active cycle so the bus is
   // fully quiet in IDLE/DONE/RETRY and straight after reset.
   always_comb begin
      wb_cyc_o = bus_act;
      wb_stb_o = bus_act;
      wb_we_o  = bus_act & we_q;
      wb_adr_o = bus_act ? ba_addr : '0;
      wb_sel_o = bus_act ? sel_q : '0;
      wb_cti_o = CTI_CLASSIC;
      wb_bte_o = BTE_LINEAR;
      if (state_q == ST_BURST) begin
         wb_cti_o = ba_last ? CTI_EOB : CTI_INCR;
         wb_bte_o = BTE_WRAP4;
      end
   end

   assign biu_dat_o = wb_dat_i;
   assign wb_dat_o  = biu_dat_i;

endmodule

// File: tb/tb_or1200_dc_wb_burst.sv
module tb_or1200_dc_wb_burst;

   logic        clk = 1'b0;
   logic        rst;
   logic        biu_read, biu_write, burst;
   logic [31:0] biu_addr;
   logic [3:0]  biu_sel;
   logic [31:0] biu_dat_i;
   logic        biudata_valid, biudata_error;
   logic [31:0] biu_dat_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;
   logic [31:0] wb_dat_i;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   or1200_dc_wb_burst #(
      .AW(32), .DW(32), .BURST_LEN(4), .RETRY_MAX(2), .RETRY_GAP(2)
   ) dut (
      .clk(clk), .rst(rst),
      .biu_read(biu_read), .biu_write(biu_write), .burst(burst),
      .biu_addr(biu_addr), .biu_sel(biu_sel), .biu_dat_i(biu_dat_i),
      .biudata_valid(biudata_valid), .biudata_error(biudata_error),
      .biu_dat_o(biu_dat_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .wb_dat_i(wb_dat_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp_adr [4];
      logic [2:0]  exp_cti [4];
      exp_adr = '{32'h104, 32'h108, 32'h10C, 32'h100};
      exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};

      rst = 1'b0; biu_read = 1'b0; biu_write = 1'b0; burst = 1'b0;
      biu_addr = '0; biu_sel = '0; biu_dat_i = '0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;

      // Reset state
      tick(); tick(); mid();
      chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
      chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
      chk("rst_we",  {31'd0, wb_we_o}, 32'd0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
      chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
      chk("rst_bte", {30'd0, wb_bte_o}, 32'd0);
      chk("rst_vld", {31'd0, biudata_valid}, 32'd0);
      chk("rst_err", {31'd0, biudata_error}, 32'd0);

      // Read burst at 0x104, ack every cycle
      tick(); rst = 1'b1; biu_read = 1'b1; burst = 1'b1; biu_addr = 32'h104; biu_sel = 4'hF;
      mid(); chk("t1_latency_cyc", {31'd0, wb_cyc_o}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hA0A0_0000 + i;
         mid();
         chk("t1_cyc", {31'd0, wb_cyc_o}, 32'd1);
         chk("t1_adr", wb_adr_o, exp_adr[i]);
         chk("t1_cti", {29'd0, wb_cti_o}, {29'd0, exp_cti[i]});
         chk("t1_bte", {30'd0, wb_bte_o}, 32'd1);
         chk("t1_we",  {31'd0, wb_we_o}, 32'd0);
         chk("t1_vld", {31'd0, biudata_valid}, 32'd1);
         chk("t1_dat", biu_dat_o, 32'hA0A0_0000 + i);
      end
      tick(); wb_ack_i = 1'b0;
      mid(); chk("t1_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      chk("t1_vld_drop", {31'd0, biudata_valid}, 32'd0);
      tick(); mid(); chk("t1_done_hold", {31'd0, wb_cyc_o}, 32'd0);
      biu_read = 1'b0; burst = 1'b0;

      // Single write to 0x2000 with 3 wait states
      tick(); biu_write = 1'b1; biu_addr = 32'h2000; biu_sel = 4'b0011; biu_dat_i = 32'hDEAD_BEEF;
      mid(); chk("t2_latency_cyc", {31'd0, wb_cyc_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); mid();
         chk("t2_cyc", {31'd0, wb_cyc_o}, 32'd1);
         chk("t2_we",  {31'd0, wb_we_o}, 32'd1);
         chk("t2_sel", {28'd0, wb_sel_o}, 32'h3);
         chk("t2_cti", {29'd0, wb_cti_o}, 32'd0);
         chk("t2_bte", {30'd0, wb_bte_o}, 32'd0);
         chk("t2_adr", wb_adr_o, 32'h2000);
         chk("t2_wdat", wb_dat_o, 32'hDEAD_BEEF);
         chk("t2_vld_wait", {31'd0, biudata_valid}, 32'd0);
      end
      tick(); wb_ack_i = 1'b1;
      mid(); chk("t2_vld", {31'd0, biudata_valid}, 32'd1);
      chk("t2_err", {31'd0, biudata_error}, 32'd0);
      tick(); wb_ack_i = 1'b0;
      mid(); chk("t2_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      biu_write = 1'b0;

      // Read burst with ack+err on beat 2
      tick(); biu_read = 1'b1; burst = 1'b1; biu_addr = 32'h40; biu_sel = 4'hF;
      mid();
      tick(); wb_ack_i = 1'b1;
      mid(); chk("t3_b1_vld", {31'd0, biudata_valid}, 32'd1);
      chk("t3_b1_adr", wb_adr_o, 32'h40);
      tick(); wb_err_i = 1'b1;
      mid(); chk("t3_b2_err", {31'd0, biudata_error}, 32'd1);
      chk("t3_b2_vld", {31'd0, biudata_valid}, 32'd0);
      chk("t3_b2_adr", wb_adr_o, 32'h44);
      tick(); wb_err_i = 1'b0;
      mid(); chk("t3_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      chk("t3_vld_after", {31'd0, biudata_valid}, 32'd0);
      chk("t3_err_after", {31'd0, biudata_error}, 32'd0);
      tick(); wb_ack_i = 1'b0; biu_read = 1'b0;

      // Abort: biu_read dropped after beat 1
      tick(); biu_read = 1'b1; burst = 1'b1; biu_addr = 32'h80;
      mid();
      tick(); wb_ack_i = 1'b1;
      mid(); chk("t4_b1_vld", {31'd0, biudata_valid}, 32'd1);
      tick(); biu_read = 1'b0;
      mid(); chk("t4_drop_vld", {31'd0, biudata_valid}, 32'd0);
      tick(); biu_read = 1'b1; biu_addr = 32'h200;
      mid(); chk("t4_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      chk("t4_stb_drop", {31'd0, wb_stb_o}, 32'd0);
      chk("t4_vld_late_ack", {31'd0, biudata_valid}, 32'd0);
      // A fresh request is accepted straight away, so the abort went to IDLE
      tick(); mid();
      chk("t4_idle_restart", {31'd0, wb_cyc_o}, 32'd1);
      chk("t4_restart_adr", wb_adr_o, 32'h200);
      chk("t4_restart_vld", {31'd0, biudata_valid}, 32'd1);
      tick(); mid(); chk("t5_b1_adr", wb_adr_o, 32'h204);

      // Reset during beat 2
      tick(); rst = 1'b0;
      mid(); chk("t5_rst_vld", {31'd0, biudata_valid}, 32'd0);
      chk("t5_rst_err", {31'd0, biudata_error}, 32'd0);
      tick(); rst = 1'b1; biu_addr = 32'h300; wb_ack_i = 1'b0;
      mid();
      chk("t5_cyc", {31'd0, wb_cyc_o}, 32'd0);
      chk("t5_stb", {31'd0, wb_stb_o}, 32'd0);
      chk("t5_we",  {31'd0, wb_we_o}, 32'd0);
      chk("t5_adr", wb_adr_o, 32'd0);
      chk("t5_sel", {28'd0, wb_sel_o}, 32'd0);
      chk("t5_cti", {29'd0, wb_cti_o}, 32'd0);
      chk("t5_bte", {30'd0, wb_bte_o}, 32'd0);
      tick(); wb_ack_i = 1'b1;
      mid(); chk("t5_new_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("t5_new_adr", wb_adr_o, 32'h300);
      chk("t5_new_cti", {29'd0, wb_cti_o}, 32'h2);
      chk("t5_new_vld", {31'd0, biudata_valid}, 32'd1);
      tick(); mid(); chk("t5_new_adr2", wb_adr_o, 32'h304);
      tick(); wb_ack_i = 1'b0; biu_read = 1'b0; burst = 1'b0;
      mid();

`ifdef OR1200_DC_WB_RETRY_EN
      // rty twice, then ack: re-issue at same address after 2 idle cycles
      tick(); biu_read = 1'b1; biu_addr = 32'h500;
      mid();
      for (int k = 0; k < 2; k++) begin
         tick(); wb_rty_i = 1'b1;
         mid(); chk("t6_rty_cyc", {31'd0, wb_cyc_o}, 32'd1);
         chk("t6_rty_adr", wb_adr_o, 32'h500);
         chk("t6_rty_err", {31'd0, biudata_error}, 32'd0);
         chk("t6_rty_vld", {31'd0, biudata_valid}, 32'd0);
         tick(); wb_rty_i = 1'b0;
         mid(); chk("t6_gap1_cyc", {31'd0, wb_cyc_o}, 32'd0);
         tick(); mid(); chk("t6_gap2_cyc", {31'd0, wb_cyc_o}, 32'd0);
      end
      tick(); wb_ack_i = 1'b1;
      mid(); chk("t6_reissue_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("t6_reissue_adr", wb_adr_o, 32'h500);
      chk("t6_reissue_vld", {31'd0, biudata_valid}, 32'd1);
      chk("t6_reissue_err", {31'd0, biudata_error}, 32'd0);
      tick(); wb_ack_i = 1'b0; biu_read = 1'b0;
      mid();

      // rty three times: error on the third
      tick(); biu_read = 1'b1; biu_addr = 32'h600;
      mid();
      for (int k = 0; k < 3; k++) begin
         tick(); wb_rty_i = 1'b1;
         mid(); chk("t7_err", {31'd0, biudata_error}, (k == 2) ? 32'd1 : 32'd0);
         chk("t7_vld", {31'd0, biudata_valid}, 32'd0);
         tick(); wb_rty_i = 1'b0;
         mid(); chk("t7_gap_cyc", {31'd0, wb_cyc_o}, 32'd0);
         tick(); mid();
      end
      chk("t7_done_cyc", {31'd0, wb_cyc_o}, 32'd0);
      biu_read = 1'b0;
`else
      // rty without the retry feature terminates like err
      tick(); biu_read = 1'b1; biu_addr = 32'h700;
      mid();
      tick(); wb_rty_i = 1'b1;
      mid(); chk("t6_rty_err", {31'd0, biudata_error}, 32'd1);
      chk("t6_rty_vld", {31'd0, biudata_valid}, 32'd0);
      tick(); wb_rty_i = 1'b0;
      mid(); chk("t6_rty_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      tick(); mid(); chk("t6_done_hold", {31'd0, wb_cyc_o}, 32'd0);
      biu_read = 1'b0;
`endif

      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
